i2c_byte_rx: RTL
================

Name: i2c_byte_rx

Overview:
Receive-side bit-to-byte stage of the I2C slave interface. Synchronises raw SCL/SDA and detects START and STOP. After a START it shifts in 8 data bits MSB-first and drives the ACK/NACK slot. Its byte output and one-cycle valid strobe feed the downstream holding register's d/ld inputs directly.

Parameters:
w, 8, data word width (bits per I2C transfer before the ACK slot)
sync_stages, 2, synchroniser flops per line (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x SCL frequency
rst_b  input  1  asynchronous reset, active low
scl_i  input  1  raw SCL from pad
sda_i  input  1  raw SDA from pad
ack_en  input  1  1 = ACK received bytes; 0 = NACK
sda_oe  output  1  1 = pull SDA low (open-drain enable)
data  output  w  last completed byte, MSB = first bit received
data_vld  output  1  one-cycle strobe: data updated (drives downstream ld)
start_det  output  1  one-cycle strobe: START or repeated START seen
stop_det  output  1  one-cycle strobe: STOP seen
busy  output  1  1 between START and STOP

Behaviour:
- Reset (rst_b=0, async):
  - state=IDLE, data=0, data_vld=0, sda_oe=0, start_det=0, stop_det=0, busy=0.
  - Synchroniser flops load 1 (bus idle-high).
  - Bit counter=0, shift register=0.
- Synchronisation and edge detection:
  - Each line passes through sync_stages flops plus one delay flop.
  - Edges are decoded from synced value vs delayed value.
  - Latency from pad change to edge decode: sync_stages+1 clk.
- Event decode (all evaluated on the same clk):
  - scl_rise / scl_fall: synced SCL edges.
  - START: SDA fall while synced SCL=1 and SCL not falling.
  - STOP: SDA rise while synced SCL=1 and SCL not falling.
- Event priority: START/STOP > SCL edges. START and STOP are mutually exclusive by construction.
- States: IDLE, RECV, ACK, ACK_HOLD.
- IDLE:
  - START -> RECV; counter=0; busy=1; start_det pulses.
  - Everything else ignored.
- RECV:
  - On each scl_rise: shift_reg <= {shift_reg[w-2:0], sda_synced}; counter++.
  - When counter reaches w on a rise:
    - data <= completed shift value.
    - data_vld=1 exactly one clk later, for one clk.
    - ack_en is latched in that same cycle.
    - Move to ACK.
- ACK:
  - On the next scl_fall: sda_oe <= latched ack_en; go to ACK_HOLD.
- ACK_HOLD:
  - The ACK slot's scl_rise is ignored.
  - On the following scl_fall: sda_oe <= 0; counter=0; go to RECV for the next byte.
- STOP in any non-IDLE state:
  - -> IDLE; sda_oe=0; busy=0; stop_det pulses.
  - A partial byte is discarded: no data_vld, data unchanged.
- START in any non-IDLE state (repeated START):
  - -> RECV; counter=0; sda_oe=0; start_det pulses.
  - Partial byte discarded; busy stays 1.
- data holds its value until the next completed byte or reset. It never changes without data_vld.
- sda_oe changes only on scl_fall or on reset/STOP/START. It never changes while synced SCL=1.
- Mid-operation reset: all outputs return to reset values immediately. The bus must see a new START before any further reception.
- Counter width: clog2(w+1). It saturates at w and never wraps within a byte.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants IDLE/RECV/ACK/ACK_HOLD (2 bits).
  - Bus idle level constant (1).
  - These are reused by the future transmit stage.
- Sub-module i2c_sync_edge:
  - Parameterised by sync_stages.
  - Outputs: synced level, rise, fall.
  - Instantiated once for SCL and once for SDA.
- FSM, counter and shift register stay in i2c_byte_rx.

Test Plan:
- Reset then idle bus (SCL=SDA=1 for 100 clk) -> all outputs 0, busy=0, no strobes.
- START, bits 1,0,1,0,0,1,0,1, ack_en=1 ->
  - start_det single pulse.
  - data=0xA5 with one-cycle data_vld.
  - sda_oe=1 from the 8th bit's SCL fall to the 9th SCL fall, then 0.
- Same byte with ack_en=0 -> data=0xA5, data_vld pulses, sda_oe stays 0 (NACK).
- START, 4 bits, STOP -> stop_det pulses, busy=0, no data_vld, data keeps its previous value.
- Byte 0x3C, then repeated START, then byte 0xC3 ->
  - start_det pulses twice, busy stays 1.
  - data_vld pulses twice, with data 0x3C then 0xC3.
- rst_b low for 1 clk during bit 5 -> outputs return to reset values at once. The remaining SCL pulses are ignored until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus idle level.
// Reused by both the receive and the transmit stages.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    ACK      = 2'd2,
    ACK_HOLD = 2'd3
  } i2c_state_e;

  localparam logic BUS_IDLE = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one open-drain line, plus a delay flop for edge decode.
// Flops reset to the bus idle level so that leaving reset never produces a false edge.
module i2c_sync_edge
  import i2c_pkg::*;
#(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [sync_stages-1:0] sync_r;
  logic                   dly_r;

  // synchroniser chain and one-cycle delayed copy of the synced level
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_r <= {sync_stages{BUS_IDLE}};
      dly_r  <= BUS_IDLE;
    end else begin
      sync_r <= {sync_r[sync_stages-2:0], line};
      dly_r  <= sync_r[sync_stages-1];
    end
  end

  assign level = sync_r[sync_stages-1];
  assign rise  = level & ~dly_r;
  assign fall  = ~level & dly_r;

endmodule

// File: rtl/i2c_byte_rx.sv
// I2C slave receive stage: START/STOP detection, MSB-first byte shift-in and ACK/NACK slot.
// All outputs are registered; data/data_vld feed a downstream holding register directly.
module i2c_byte_rx
  import i2c_pkg::*;
#(
  parameter int w           = 8,
  parameter int sync_stages = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         scl_i,
  input  logic         sda_i,
  input  logic         ack_en,
  output logic         sda_oe,
  output logic [w-1:0] data,
  output logic         data_vld,
  output logic         start_det,
  output logic         stop_det,
  output logic         busy
);

  localparam int CNT_W = $clog2(w + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(w - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(w);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_ev_s, stop_ev_s;

  i2c_sync_edge #(.sync_stages(sync_stages)) u_scl (
    .clk(clk), .rst_b(rst_b), .line(scl_i),
    .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
  );

  i2c_sync_edge #(.sync_stages(sync_stages)) u_sda (
    .clk(clk), .rst_b(rst_b), .line(sda_i),
    .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
  );

  assign start_ev_s = sda_fall_s & scl_lvl_s & ~scl_fall_s;
  assign stop_ev_s  = sda_rise_s & scl_lvl_s & ~scl_fall_s;

  i2c_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [w-1:0]   shift_r, shift_s;
  logic [w-1:0]   data_s;
  logic           ack_r, ack_s;
  logic           oe_s, vld_s, start_s, stop_s, busy_s;

  // next-state, datapath and strobe decode; bus events outrank SCL edges
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    data_s  = data;
    ack_s   = ack_r;
    oe_s    = sda_oe;
    vld_s   = 1'b0;
    start_s = 1'b0;
    stop_s  = 1'b0;
    busy_s  = busy;
    if (start_ev_s) begin
      state_s = RECV;
      cnt_s   = CNT_ZERO;
      shift_s = {w{1'b0}};
      oe_s    = 1'b0;
      start_s = 1'b1;
      busy_s  = 1'b1;
    end else if (stop_ev_s && (state_r != IDLE)) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
      shift_s = {w{1'b0}};
      oe_s    = 1'b0;
      stop_s  = 1'b1;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        RECV: begin
          if (scl_rise_s) begin
            shift_s = {shift_r[w-2:0], sda_lvl_s};
            cnt_s   = (cnt_r == CNT_FULL) ? cnt_r : cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              data_s  = {shift_r[w-2:0], sda_lvl_s};
              vld_s   = 1'b1;
              ack_s   = ack_en;
              state_s = ACK;
            end else begin
              state_s = RECV;
            end
          end else begin
            state_s = RECV;
          end
        end
        ACK: begin
          if (scl_fall_s) begin
            oe_s    = ack_r;
            state_s = ACK_HOLD;
          end else begin
            state_s = ACK;
          end
        end
        ACK_HOLD: begin
          // the ACK slot's own rising edge is deliberately not sampled
          if (scl_fall_s) begin
            oe_s    = 1'b0;
            cnt_s   = CNT_ZERO;
            state_s = RECV;
          end else begin
            state_s = ACK_HOLD;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      shift_r   <= {w{1'b0}};
      ack_r     <= 1'b0;
      data      <= {w{1'b0}};
      data_vld  <= 1'b0;
      sda_oe    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      ack_r     <= ack_s;
      data      <= data_s;
      data_vld  <= vld_s;
      sda_oe    <= oe_s;
      start_det <= start_s;
      stop_det  <= stop_s;
      busy      <= busy_s;
    end
  end

endmodule
